sdm_cic_decimator: RTL and testbench



---
 rtl/sdm_pkg.sv | 36 +++
 rtl/sdm_cic_comb.sv | 56 +++++
 rtl/sdm_cic_decimator.sv | 82 ++++++++
 tb/tb_sdm_cic_decimator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
// Shared SDM definitions: CIC sizing, PCM saturation and the bit-to-level mapping
// used by both the DAC model and the CIC decoder.
package sdm_pkg;

    localparam int   CIC_ORDER   = 3;
    // Bitstream value that represents +1; the other value represents -1.
    localparam logic SDM_POS_BIT = 1'b1;

    typedef struct packed {
        logic signed [31:0] val;
        logic               sat;
    } sat_t;

    function automatic int cic_width(input int decim, input int order);
        return 2 + order * $clog2(decim);
    endfunction

    function automatic sat_t sat_pcm(input logic signed [31:0] value, input int out_w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sat_t               r;
        hi    = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo    = -hi - 32'sd1;
        r.val = value;
        r.sat = 1'b0;
        if (value > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (value < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdm_cic_comb.sv
// Registered CIC comb cascade (differential delay 1) on the decimated sample,
// followed by output scaling and PCM saturation.
module sdm_cic_comb
    import sdm_pkg::*;
#(
    parameter int W     = 20,
    parameter int ORDER = 3,
    parameter int SHIFT = 3,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    input  logic [W-1:0]            i_data,
    output logic                    o_valid,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_sat
);

    // Small ratios need a left shift to fill the PCM range.
    localparam int SHR = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHL = (SHIFT < 0) ? -SHIFT : 0;

    logic [ORDER-1:0][W-1:0] r_dly;
    logic [ORDER:0][W-1:0]   w_c;
    logic signed [31:0]      w_scaled;
    sat_t                    w_sat;
    logic [31-OUT_W:0]       w_unused_hi;

    assign w_c[0] = i_data;

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        assign w_c[k+1] = w_c[k] - r_dly[k];
    end

    assign w_scaled    = (32'($signed(w_c[ORDER])) >>> SHR) <<< SHL;
    assign w_sat       = sat_pcm(w_scaled, OUT_W);
    assign w_unused_hi = w_sat.val[31:OUT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sat   <= 1'b0;
        end else begin
            o_valid <= i_valid;
            o_sat   <= i_valid & w_sat.sat;
            if (i_valid) begin
                r_dly  <= w_c[ORDER-1:0];
                o_data <= w_sat.val[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sdm_cic_decimator.sv
// CIC decimator turning a 1-bit sigma-delta stream into signed PCM; integrators and
// the block counter live here, combs/scaling/saturation in sdm_cic_comb.
module sdm_cic_decimator
    import sdm_pkg::*;
#(
    parameter int DECIM = 64,
    parameter int OUT_W = 16,
    parameter int ORDER = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic                    sdm_in,
    output logic                    valid_out,
    output logic signed [OUT_W-1:0] audio_out,
    output logic                    sat_out
);

    localparam int W     = cic_width(DECIM, ORDER);
    localparam int CW    = $clog2(DECIM);
    localparam int SHIFT = ORDER * CW - (OUT_W - 1);

    if (ORDER != CIC_ORDER) begin : g_order_chk
        $error("sdm_cic_decimator: ORDER must be %0d", CIC_ORDER);
    end
    if (DECIM < 4 || DECIM > 256 || (DECIM & (DECIM - 1)) != 0) begin : g_decim_chk
        $error("sdm_cic_decimator: DECIM must be a power of two in 4..256");
    end

    logic [CW-1:0]           r_cnt;
    logic [ORDER-1:0][W-1:0] r_int;
    logic [W-1:0]            r_dec;
    logic [1:0]              r_vld_pipe;
    logic [W-1:0]            w_x;
    logic                    w_last;

    assign w_x    = (sdm_in == SDM_POS_BIT) ? W'(1) : {W{1'b1}};
    assign w_last = valid_in && (r_cnt == CW'(DECIM - 1));

    // Integrator sums wrap modulo 2^W; the comb differences undo the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_int <= '0;
        end else if (valid_in) begin
            r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
            r_int[0] <= r_int[0] + w_x;
            for (int k = 1; k < ORDER; k++) begin
                r_int[k] <= r_int[k] + r_int[k-1];
            end
        end
    end

    // [0]: block completed last edge; [1]: decimated sample ready for the comb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_dec      <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_last};
            if (r_vld_pipe[0]) begin
                r_dec <= r_int[ORDER-1];
            end
        end
    end

    sdm_cic_comb #(
        .W     (W),
        .ORDER (ORDER),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_comb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_vld_pipe[1]),
        .i_data  (r_dec),
        .o_valid (valid_out),
        .o_data  (audio_out),
        .o_sat   (sat_out)
    );

endmodule

// File: tb/tb_sdm_cic_decimator.sv
// Table-driven bench for sdm_cic_decimator with a scoreboard of expected output
// cycles and samples, plus a mid-block reset sequence.
module tb_sdm_cic_decimator;

    localparam int DECIM = 64;
    localparam int NBLK  = 5;

    typedef enum int {M_ONE, M_ZERO, M_ALT, M_DC} mode_e;

    typedef struct {
        mode_e mode;
        bit    gap;
        int    u;
        int    exp_a;
        bit    exp_s;
        int    tol;
    } vec_t;

    typedef struct {
        int cyc;
        bit chk;
        int exp_a;
        bit exp_s;
        int tol;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic sdm_in = 1'b0;
    logic valid_out;
    logic sat_out;
    logic signed [15:0] audio_out;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_v = 0;
    int   exp_space = 64;
    bit   alt_ph = 1'b0;
    int   sdm_s = 0;
    exp_t q[$];
    vec_t vecs[6];

    sdm_cic_decimator #(.DECIM(DECIM), .OUT_W(16), .ORDER(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .sdm_in    (sdm_in),
        .valid_out (valid_out),
        .audio_out (audio_out),
        .sat_out   (sat_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", nm, act, exp, tol, cyc);
        end
    endtask

    // Scoreboard consumer: every valid_out must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && valid_out) begin
                if (q.size() == 0) begin
                    check("unexpected valid_out", cyc, -1, 0);
                end else begin
                    e = q.pop_front();
                    check("valid_out cycle", cyc, e.cyc, 0);
                    if (last_v != 0) check("valid_out spacing", cyc - last_v, exp_space, 0);
                    last_v = cyc;
                    if (e.chk) begin
                        check("audio_out", int'(audio_out), e.exp_a, e.tol);
                        check("sat_out", int'(sat_out), int'(e.exp_s), 0);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        q.delete();
        last_v = 0;
        repeat (3) @(negedge clk);
        check("reset audio_out", int'(audio_out), 0, 0);
        check("reset valid_out", int'(valid_out), 0, 0);
        check("reset sat_out", int'(sat_out), 0, 0);
        rst_n = 1'b1;
    endtask

    // First-order sigma-delta model for the DC loopback cases.
    task automatic gen(input mode_e m, input int u, output logic b);
        case (m)
            M_ONE:  b = 1'b1;
            M_ZERO: b = 1'b0;
            M_ALT: begin
                b      = ~alt_ph;
                alt_ph = ~alt_ph;
            end
            default: begin
                b     = (sdm_s >= 0);
                sdm_s = sdm_s + u - (b ? 32768 : -32768);
            end
        endcase
    endtask

    task automatic run_block(input vec_t v, input bit chk);
        logic b;
        exp_t e;
        for (int i = 0; i < DECIM; i++) begin
            gen(v.mode, v.u, b);
            if (v.gap) begin
                @(negedge clk);
                valid_in = 1'b0;
                sdm_in   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            valid_in = 1'b1;
            sdm_in   = b;
            if (i == DECIM - 1) begin
                e.cyc   = cyc + 3;
                e.chk   = chk;
                e.exp_a = v.exp_a;
                e.exp_s = v.exp_s;
                e.tol   = v.tol;
                q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        valid_in = 1'b0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("drain timeout pending", q.size(), 0, 0);
            q.delete();
        end
    endtask

    initial begin
        vecs[0] = '{M_ONE,  1'b0, 0,      32767,  1'b1, 0};
        vecs[1] = '{M_ZERO, 1'b0, 0,      -32768, 1'b0, 0};
        vecs[2] = '{M_ALT,  1'b0, 0,      0,      1'b0, 0};
        vecs[3] = '{M_ALT,  1'b1, 0,      0,      1'b0, 0};
        vecs[4] = '{M_DC,   1'b0, 16384,  16384,  1'b0, 328};
        vecs[5] = '{M_DC,   1'b0, -8192,  -8192,  1'b0, 328};

        foreach (vecs[t]) begin
            exp_space = vecs[t].gap ? 2 * DECIM : DECIM;
            alt_ph    = 1'b0;
            sdm_s     = 0;
            do_reset();
            for (int b = 0; b < NBLK; b++) run_block(vecs[t], b >= 2);
            drain();
        end

        // Reset 30 beats into a block: partial state is dropped, counting restarts.
        exp_space = DECIM;
        do_reset();
        run_block(vecs[0], 1'b0);
        run_block(vecs[0], 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            sdm_in   = 1'b1;
        end
        do_reset();
        for (int b = 0; b < 3; b++) run_block(vecs[0], b == 2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
